// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the
// in-order WB stage (always wins) and a long-latency secondary unit. One
// secondary result is buffered. A scoreboard of pending secondary
// destinations drives decode hazard stalls. A starvation counter requests a
// pipeline bubble so that the buffered result can drain.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pri_we,
  input  logic [REG_AW-1:0] pri_rd,
  input  logic [DATA_W-1:0] pri_wdata,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [REG_AW-1:0] sec_rd,
  input  logic [DATA_W-1:0] sec_wdata,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       busy_vec
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              holdValid_q, holdValid_d;
  logic [REG_AW-1:0] holdRd_q, holdRd_d;
  logic [DATA_W-1:0] holdData_q, holdData_d;
  logic [31:1]       busy_q, busy_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic              pipeStall_q, pipeStall_d;

  logic        priWrite;
  logic        drain;
  logic        accept;
  logic [31:0] busyFull;
  logic [31:0] drainMask;
  logic [31:0] busyVisible;
  logic [31:0] busyNext;

  // Classify this cycle's port activity: primary write, buffer drain, accept
  always_comb begin
    priWrite  = pri_we && (pri_rd != '0);
    drain     = holdValid_q && !priWrite;
    accept    = sec_valid && !holdValid_q;
    sec_ready = !holdValid_q;
  end

  // Write port mux: the primary always wins, and the buffer drains into idle slots
  always_comb begin
    rf_we    = 1'b0;
    rf_wr    = '0;
    rf_wdata = '0;
    if (priWrite) begin
      rf_we    = 1'b1;
      rf_wr    = pri_rd;
      rf_wdata = pri_wdata;
    end else if (holdValid_q) begin
      rf_we    = 1'b1;
      rf_wr    = holdRd_q;
      rf_wdata = holdData_q;
    end
  end

  // Hazard detection; the register being drained is bypassed by the RF, so it does not stall
  always_comb begin
    busyFull    = {busy_q, 1'b0};
    drainMask   = drain ? (32'd1 << holdRd_q) : 32'd0;
    busyVisible = busyFull & ~drainMask;
    dec_stall   = busyVisible[dec_rs1] || busyVisible[dec_rs2] || busyVisible[dec_rd];
    busy_vec    = busyFull;
    pipe_stall  = pipeStall_q;
  end

  // Next state for the buffer, scoreboard and starvation tracking
  always_comb begin
    holdValid_d = holdValid_q;
    holdRd_d    = holdRd_q;
    holdData_d  = holdData_q;
    if (drain) begin
      holdValid_d = 1'b0;
    end
    if (accept && (sec_rd != '0)) begin
      holdValid_d = 1'b1;
      holdRd_d    = sec_rd;
      holdData_d  = sec_wdata;
    end

    if (holdValid_q && priWrite) begin
      starveCnt_d = (starveCnt_q == LIMIT) ? starveCnt_q : starveCnt_q + CNT_W'(1);
    end else begin
      starveCnt_d = '0;
    end
    pipeStall_d = holdValid_d && (starveCnt_d == LIMIT);

    busyNext = busyFull;
    if (drain) begin
      busyNext[holdRd_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0) && !dec_stall) begin
      busyNext[issue_rd] = 1'b1;
    end
    busy_d = busyNext[31:1];
  end

  // State register with synchronous reset that discards any in-flight result
  always_ff @(posedge clk) begin
    if (reset) begin
      holdValid_q <= 1'b0;
      holdRd_q    <= '0;
      holdData_q  <= '0;
      busy_q      <= '0;
      starveCnt_q <= '0;
      pipeStall_q <= 1'b0;
    end else begin
      holdValid_q <= holdValid_d;
      holdRd_q    <= holdRd_d;
      holdData_q  <= holdData_d;
      busy_q      <= busy_d;
      starveCnt_q <= starveCnt_d;
      pipeStall_q <= pipeStall_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a table of per-cycle input vectors, each with
// hand-computed expected outputs, plus a hand-written reset-with-state sequence.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pri_we;
  logic [4:0]  pri_rd;
  logic [31:0] pri_wdata;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_rd;
  logic [31:0] sec_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        priWe;
    logic [4:0]  priRd;
    logic [31:0] priData;
    logic        secValid;
    logic [4:0]  secRd;
    logic [31:0] secData;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        expReady;
    logic        expWe;
    logic [4:0]  expWr;
    logic [31:0] expData;
    logic        expDecStall;
    logic        expPipeStall;
    logic [31:0] expBusy;
  } vec_t;

  vec_t vecs[$];

  regfile_wb_arbiter #(.DATA_W(32), .REG_AW(5), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .pri_we(pri_we),
    .pri_rd(pri_rd),
    .pri_wdata(pri_wdata),
    .sec_valid(sec_valid),
    .sec_ready(sec_ready),
    .sec_rd(sec_rd),
    .sec_wdata(sec_wdata),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .dec_rd(dec_rd),
    .dec_stall(dec_stall),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we),
    .rf_wr(rf_wr),
    .rf_wdata(rf_wdata),
    .busy_vec(busy_vec)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pri_we      = v.priWe;
    pri_rd      = v.priRd;
    pri_wdata   = v.priData;
    sec_valid   = v.secValid;
    sec_rd      = v.secRd;
    sec_wdata   = v.secData;
    issue_valid = v.issueValid;
    issue_rd    = v.issueRd;
    dec_rs1     = v.rs1;
    dec_rs2     = v.rs2;
    dec_rd      = v.rd;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkField($sformatf("v%0d sec_ready", idx), {31'd0, sec_ready}, {31'd0, v.expReady});
    checkField($sformatf("v%0d rf_we", idx), {31'd0, rf_we}, {31'd0, v.expWe});
    checkField($sformatf("v%0d rf_wr", idx), {27'd0, rf_wr}, {27'd0, v.expWr});
    checkField($sformatf("v%0d rf_wdata", idx), rf_wdata, v.expData);
    checkField($sformatf("v%0d dec_stall", idx), {31'd0, dec_stall}, {31'd0, v.expDecStall});
    checkField($sformatf("v%0d pipe_stall", idx), {31'd0, pipe_stall}, {31'd0, v.expPipeStall});
    checkField($sformatf("v%0d busy_vec", idx), busy_vec, v.expBusy);
    testsRun++;
    if (pipe_stall === 1'b1 && pri_we === 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL v%0d stall contract: got pri_we=1 under pipe_stall, expected pri_we=0", idx);
    end
  endtask

  initial begin
    vec_t idle;
    testsRun    = 0;
    testsFailed = 0;

    idle = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0,
             1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0};

    //           pwe   prd    pdata          sv    srd    sdata          iv    ird    rs1    rs2    rd     rdy   we    wr     wdata          ds    ps    busy
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h20});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h20});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h20});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 5'd3, 32'h33,       1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0, 32'h80});
    vecs.push_back('{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0, 32'h80});
    vecs.push_back('{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0, 32'h80});
    vecs.push_back('{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0, 32'h80});
    vecs.push_back('{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0, 32'h80});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h11111111, 1'b0, 1'b1, 32'h80});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 5'd0, 32'hBB,       1'b1, 5'd0, 32'hAA,       1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 32'h5,        1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b1, 1'b0, 32'h200});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h5,        1'b0, 1'b0, 32'h200});
    vecs.push_back('{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h200});
    vecs.push_back('{1'b1, 5'd4, 32'h44,       1'b1, 5'd12, 32'hC,       1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b0, 1'b0, 32'h200});

    reset = 1'b1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
    end

    // Buffer now holds rd=12 and busy[9] is set; reset must discard both
    @(posedge clk);
    #1 applyStimulus(idle);
    reset = 1'b1;
    @(negedge clk);
    checkField("pre-reset rf_wr", {27'd0, rf_wr}, 32'd12);
    checkField("pre-reset busy_vec", busy_vec, 32'h200);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkField("post-reset rf_we", {31'd0, rf_we}, 32'd0);
    checkField("post-reset sec_ready", {31'd0, sec_ready}, 32'd1);
    checkField("post-reset busy_vec", busy_vec, 32'h0);
    checkField("post-reset pipe_stall", {31'd0, pipe_stall}, 32'd0);
    checkField("post-reset dec_stall", {31'd0, dec_stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
